phv_stage_buffer: RTL and testbench

PHV_STAGE_BUFFER -- requirements
Module: phv_stage_buffer

---
 rtl/phv_stage_buffer_pkg.sv | 16 +
 rtl/phv_stage_buffer_mem.sv | 44 ++++
 rtl/phv_stage_buffer.sv | 157 +++++++++++++++
 tb/tb_phv_stage_buffer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/phv_stage_buffer_pkg.sv
// Shared RMT pipeline widths and small helpers used by the PHV stage buffer.
package phv_stage_buffer_pkg;

    localparam int unsigned PHV_LEN              = 48*8 + 32*8 + 16*8 + 5*20 + 256;
    localparam int unsigned KEY_LEN              = 48*2 + 32*2 + 16*2 + 5;
    localparam int unsigned ACT_LEN              = 25;
    localparam int unsigned C_S_AXIS_DATA_WIDTH  = 512;
    localparam int unsigned C_S_AXIS_TUSER_WIDTH = 128;
    localparam int unsigned CNT_W                = 32;

    // Saturating increment for the statistics counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

endpackage

// File: rtl/phv_stage_buffer_mem.sv
// DEPTH x WIDTH simple dual-port RAM: synchronous write, registered read that
// holds its value when no read is issued. Only the output register is reset.
module phv_fifo_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 1124,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/phv_stage_buffer.sv
// Elastic PHV buffer between RMT stages plus a one-deep control-path slice.
// Define PHV_STAGE_BUFFER_STATS_EN to build the accepted/dropped PHV counters.
module phv_stage_buffer #(
    parameter int unsigned PHV_LEN              = phv_stage_buffer_pkg::PHV_LEN,
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = phv_stage_buffer_pkg::C_S_AXIS_DATA_WIDTH,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = phv_stage_buffer_pkg::C_S_AXIS_TUSER_WIDTH,
    parameter int unsigned DEPTH                = 16,
    parameter int unsigned AFULL_THRESH         = 12
) (
    input  logic                              axis_clk,
    input  logic                              aresetn,
    input  logic [PHV_LEN-1:0]                phv_in,
    input  logic                              phv_in_valid,
    output logic                              stg_ready,
    output logic [PHV_LEN-1:0]                phv_out,
    output logic                              phv_out_valid,
    input  logic                              stg_ready_in,
    output logic                              overflow,
    output logic [31:0]                       pkt_in_cnt,
    output logic [31:0]                       drop_cnt,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
    input  logic                              c_s_axis_tvalid,
    input  logic                              c_s_axis_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
    output logic                              c_m_axis_tvalid,
    output logic                              c_m_axis_tlast
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned OCC_W  = PTR_W + 1;
    localparam int unsigned KEEP_W = C_S_AXIS_DATA_WIDTH / 8;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             stg_ready_q, stg_ready_d;
    logic             phv_out_valid_q, phv_out_valid_d;
    logic             overflow_q, overflow_d;
    logic             empty_c, full_c, rd_en_c, wr_en_c, drop_c;

    // A full FIFO still accepts a write when a read frees the head slot this cycle.
    always_comb begin
        empty_c         = (occ_q == '0);
        full_c          = (occ_q == OCC_W'(DEPTH));
        rd_en_c         = !empty_c && stg_ready_in;
        wr_en_c         = phv_in_valid && (!full_c || rd_en_c);
        drop_c          = phv_in_valid && full_c && !rd_en_c;
        wr_ptr_d        = wr_en_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d        = rd_en_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        occ_d           = occ_q + OCC_W'(wr_en_c) - OCC_W'(rd_en_c);
        stg_ready_d     = (occ_d < OCC_W'(AFULL_THRESH));
        phv_out_valid_d = rd_en_c;
        overflow_d      = overflow_q | drop_c;
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            occ_q           <= '0;
            stg_ready_q     <= 1'b1;
            phv_out_valid_q <= 1'b0;
            overflow_q      <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            occ_q           <= occ_d;
            stg_ready_q     <= stg_ready_d;
            phv_out_valid_q <= phv_out_valid_d;
            overflow_q      <= overflow_d;
        end
    end

    assign stg_ready     = stg_ready_q;
    assign phv_out_valid = phv_out_valid_q;
    assign overflow      = overflow_q;

    phv_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (PHV_LEN)
    ) u_mem (
        .clk     (axis_clk),
        .rst_n   (aresetn),
        .wr_en   (wr_en_c),
        .wr_addr (wr_ptr_q),
        .wr_data (phv_in),
        .rd_en   (rd_en_c),
        .rd_addr (rd_ptr_q),
        .rd_data (phv_out)
    );

`ifdef PHV_STAGE_BUFFER_STATS_EN
    logic [31:0] pkt_in_cnt_q, pkt_in_cnt_d, drop_cnt_q, drop_cnt_d;

    always_comb begin
        pkt_in_cnt_d = phv_stage_buffer_pkg::sat_inc(pkt_in_cnt_q, wr_en_c);
        drop_cnt_d   = phv_stage_buffer_pkg::sat_inc(drop_cnt_q, drop_c);
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_in_cnt_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            pkt_in_cnt_q <= pkt_in_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign pkt_in_cnt = pkt_in_cnt_q;
    assign drop_cnt   = drop_cnt_q;
`else
    assign pkt_in_cnt = '0;
    assign drop_cnt   = '0;
`endif

    // Control path: plain register slice, no backpressure.
    logic [C_S_AXIS_DATA_WIDTH-1:0]  c_tdata_q, c_tdata_d;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] c_tuser_q, c_tuser_d;
    logic [KEEP_W-1:0]               c_tkeep_q, c_tkeep_d;
    logic                            c_tvalid_q, c_tvalid_d;
    logic                            c_tlast_q, c_tlast_d;

    always_comb begin
        c_tdata_d  = c_s_axis_tdata;
        c_tuser_d  = c_s_axis_tuser;
        c_tkeep_d  = c_s_axis_tkeep;
        c_tvalid_d = c_s_axis_tvalid;
        c_tlast_d  = c_s_axis_tlast;
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            c_tdata_q  <= '0;
            c_tuser_q  <= '0;
            c_tkeep_q  <= '0;
            c_tvalid_q <= 1'b0;
            c_tlast_q  <= 1'b0;
        end else begin
            c_tdata_q  <= c_tdata_d;
            c_tuser_q  <= c_tuser_d;
            c_tkeep_q  <= c_tkeep_d;
            c_tvalid_q <= c_tvalid_d;
            c_tlast_q  <= c_tlast_d;
        end
    end

    assign c_m_axis_tdata  = c_tdata_q;
    assign c_m_axis_tuser  = c_tuser_q;
    assign c_m_axis_tkeep  = c_tkeep_q;
    assign c_m_axis_tvalid = c_tvalid_q;
    assign c_m_axis_tlast  = c_tlast_q;

endmodule

// File: tb/tb_phv_stage_buffer.sv
// Directed bench for phv_stage_buffer: reset, latency, fill/overflow, full
// read+write, pointer wrap, mid-operation reset and the control slice.
module tb_phv_stage_buffer;
    import phv_stage_buffer_pkg::*;

    localparam int unsigned PW = PHV_LEN;
    localparam int unsigned DW = C_S_AXIS_DATA_WIDTH;
    localparam int unsigned UW = C_S_AXIS_TUSER_WIDTH;
    localparam int unsigned KW = C_S_AXIS_DATA_WIDTH / 8;
`ifdef PHV_STAGE_BUFFER_STATS_EN
    localparam int unsigned STATS = 1;
`else
    localparam int unsigned STATS = 0;
`endif

    logic          axis_clk, aresetn;
    logic [PW-1:0] phv_in, phv_out;
    logic          phv_in_valid, stg_ready, phv_out_valid, stg_ready_in, overflow;
    logic [31:0]   pkt_in_cnt, drop_cnt;
    logic [DW-1:0] c_s_axis_tdata, c_m_axis_tdata;
    logic [UW-1:0] c_s_axis_tuser, c_m_axis_tuser;
    logic [KW-1:0] c_s_axis_tkeep, c_m_axis_tkeep;
    logic          c_s_axis_tvalid, c_s_axis_tlast, c_m_axis_tvalid, c_m_axis_tlast;

    int n_tests = 0;
    int n_fail  = 0;
    logic [PW-1:0] out_q [$];

    phv_stage_buffer dut (
        .axis_clk        (axis_clk),
        .aresetn         (aresetn),
        .phv_in          (phv_in),
        .phv_in_valid    (phv_in_valid),
        .stg_ready       (stg_ready),
        .phv_out         (phv_out),
        .phv_out_valid   (phv_out_valid),
        .stg_ready_in    (stg_ready_in),
        .overflow        (overflow),
        .pkt_in_cnt      (pkt_in_cnt),
        .drop_cnt        (drop_cnt),
        .c_s_axis_tdata  (c_s_axis_tdata),
        .c_s_axis_tuser  (c_s_axis_tuser),
        .c_s_axis_tkeep  (c_s_axis_tkeep),
        .c_s_axis_tvalid (c_s_axis_tvalid),
        .c_s_axis_tlast  (c_s_axis_tlast),
        .c_m_axis_tdata  (c_m_axis_tdata),
        .c_m_axis_tuser  (c_m_axis_tuser),
        .c_m_axis_tkeep  (c_m_axis_tkeep),
        .c_m_axis_tvalid (c_m_axis_tvalid),
        .c_m_axis_tlast  (c_m_axis_tlast)
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    // Every emitted PHV lands in out_q, sampled mid-cycle.
    always @(negedge axis_clk) begin
        if (phv_out_valid === 1'b1) out_q.push_back(phv_out);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic apply_reset();
        aresetn      = 1'b0;
        phv_in_valid = 1'b0;
        stg_ready_in = 1'b0;
        step();
        step();
        aresetn = 1'b1;
        step();
        out_q.delete();
    endtask

    task automatic drain(input int exp_n, input int budget);
        stg_ready_in = 1'b1;
        for (int c = 0; c < budget && out_q.size() < exp_n; c++) step();
        step();
        step();
    endtask

    task automatic test_reset();
        n_tests++; if (stg_ready !== 1'b1) begin n_fail++; $display("FAIL rst_stg_ready: got %0b expected 1", stg_ready); end
        n_tests++; if (phv_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b expected 0", phv_out_valid); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %0b expected 0", overflow); end
        n_tests++; if (phv_out !== '0) begin n_fail++; $display("FAIL rst_phv_out: got %0h expected 0", phv_out); end
        n_tests++; if (pkt_in_cnt !== 32'd0 || drop_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_counters: got %0d/%0d expected 0/0", pkt_in_cnt, drop_cnt); end
        n_tests++; if (c_m_axis_tvalid !== 1'b0 || c_m_axis_tlast !== 1'b0 || c_m_axis_tdata !== '0) begin
            n_fail++; $display("FAIL rst_ctrl: got tvalid=%0b tlast=%0b tdata=%0h expected 0/0/0", c_m_axis_tvalid, c_m_axis_tlast, c_m_axis_tdata);
        end
    endtask

    task automatic test_single();
        apply_reset();
        stg_ready_in = 1'b1;
        phv_in       = PW'(32'hA5);
        phv_in_valid = 1'b1;
        step();
        phv_in_valid = 1'b0;
        n_tests++; if (phv_out_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got valid=%0b expected 0", phv_out_valid); end
        step();
        n_tests++; if (phv_out_valid !== 1'b1 || phv_out !== PW'(32'hA5)) begin
            n_fail++; $display("FAIL single_out: got valid=%0b data=%0h expected 1/a5", phv_out_valid, phv_out);
        end
        step();
        n_tests++; if (phv_out_valid !== 1'b0 || phv_out !== PW'(32'hA5)) begin
            n_fail++; $display("FAIL single_hold: got valid=%0b data=%0h expected 0/a5", phv_out_valid, phv_out);
        end
        n_tests++; if (stg_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %0b expected 1", stg_ready); end
    endtask

    task automatic test_fill();
        apply_reset();
        for (int i = 1; i <= 16; i++) begin
            phv_in       = PW'(i);
            phv_in_valid = 1'b1;
            step();
            if (i == 11) begin
                n_tests++; if (stg_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready11: got %0b expected 1", stg_ready); end
            end
            if (i == 12) begin
                n_tests++; if (stg_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready12: got %0b expected 0", stg_ready); end
            end
        end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_no_ovf: got %0b expected 0", overflow); end
        phv_in = PW'(17);
        step();
        phv_in_valid = 1'b0;
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_ovf: got %0b expected 1", overflow); end
        n_tests++; if (drop_cnt !== 32'(STATS)) begin n_fail++; $display("FAIL fill_drop_cnt: got %0d expected %0d", drop_cnt, STATS); end
        n_tests++; if (pkt_in_cnt !== 32'(16 * STATS)) begin n_fail++; $display("FAIL fill_pkt_cnt: got %0d expected %0d", pkt_in_cnt, 16 * STATS); end
        drain(16, 40);
        n_tests++; if (out_q.size() != 16) begin n_fail++; $display("FAIL fill_count: got %0d expected 16", out_q.size()); end
        for (int i = 0; i < 16 && i < out_q.size(); i++) begin
            n_tests++; if (out_q[i] !== PW'(i + 1)) begin n_fail++; $display("FAIL fill_order[%0d]: got %0h expected %0h", i, out_q[i], i + 1); end
        end
        n_tests++; if (overflow !== 1'b1 || stg_ready !== 1'b1) begin
            n_fail++; $display("FAIL fill_after_drain: got ovf=%0b ready=%0b expected 1/1", overflow, stg_ready);
        end
    endtask

    task automatic test_full_rw();
        apply_reset();
        for (int i = 1; i <= 16; i++) begin
            phv_in       = PW'(32'h200 + i);
            phv_in_valid = 1'b1;
            step();
        end
        out_q.delete();
        phv_in       = PW'(32'h99);
        stg_ready_in = 1'b1;
        step();
        phv_in_valid = 1'b0;
        stg_ready_in = 1'b0;
        n_tests++; if (phv_out_valid !== 1'b1 || phv_out !== PW'(32'h201)) begin
            n_fail++; $display("FAIL fullrw_head: got valid=%0b data=%0h expected 1/201", phv_out_valid, phv_out);
        end
        n_tests++; if (overflow !== 1'b0 || drop_cnt !== 32'd0) begin
            n_fail++; $display("FAIL fullrw_no_drop: got ovf=%0b drops=%0d expected 0/0", overflow, drop_cnt);
        end
        n_tests++; if (stg_ready !== 1'b0) begin n_fail++; $display("FAIL fullrw_ready: got %0b expected 0", stg_ready); end
        drain(17, 40);
        n_tests++; if (out_q.size() != 17) begin n_fail++; $display("FAIL fullrw_count: got %0d expected 17", out_q.size()); end
        for (int i = 0; i < 16 && i < out_q.size(); i++) begin
            n_tests++; if (out_q[i] !== PW'(32'h201 + i)) begin n_fail++; $display("FAIL fullrw_order[%0d]: got %0h expected %0h", i, out_q[i], 32'h201 + i); end
        end
        if (out_q.size() >= 17) begin
            n_tests++; if (out_q[16] !== PW'(32'h99)) begin n_fail++; $display("FAIL fullrw_last: got %0h expected 99", out_q[16]); end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        stg_ready_in = 1'b1;
        for (int k = 0; k < 40; k++) begin
            phv_in       = PW'(32'h300 + k);
            phv_in_valid = 1'b1;
            step();
            phv_in_valid = 1'b0;
            step();
        end
        drain(40, 10);
        n_tests++; if (out_q.size() != 40) begin n_fail++; $display("FAIL wrap_count: got %0d expected 40", out_q.size()); end
        for (int k = 0; k < 40 && k < out_q.size(); k++) begin
            n_tests++; if (out_q[k] !== PW'(32'h300 + k)) begin n_fail++; $display("FAIL wrap_order[%0d]: got %0h expected %0h", k, out_q[k], 32'h300 + k); end
        end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf: got %0b expected 0", overflow); end
        n_tests++; if (pkt_in_cnt !== 32'(40 * STATS)) begin n_fail++; $display("FAIL wrap_pkt_cnt: got %0d expected %0d", pkt_in_cnt, 40 * STATS); end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        for (int i = 1; i <= 5; i++) begin
            phv_in       = PW'(32'h400 + i);
            phv_in_valid = 1'b1;
            step();
        end
        phv_in_valid = 1'b0;
        n_tests++; if (pkt_in_cnt !== 32'(5 * STATS)) begin n_fail++; $display("FAIL mid_pre_cnt: got %0d expected %0d", pkt_in_cnt, 5 * STATS); end
        aresetn = 1'b0;
        step();
        step();
        aresetn = 1'b1;
        out_q.delete();
        stg_ready_in = 1'b1;
        repeat (10) step();
        n_tests++; if (out_q.size() != 0) begin n_fail++; $display("FAIL mid_no_output: got %0d outputs expected 0", out_q.size()); end
        n_tests++; if (stg_ready !== 1'b1 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL mid_flags: got ready=%0b ovf=%0b expected 1/0", stg_ready, overflow);
        end
        n_tests++; if (pkt_in_cnt !== 32'd0 || drop_cnt !== 32'd0) begin
            n_fail++; $display("FAIL mid_counters: got %0d/%0d expected 0/0", pkt_in_cnt, drop_cnt);
        end
    endtask

    task automatic test_ctrl();
        c_s_axis_tdata  = DW'(32'h1234);
        c_s_axis_tuser  = UW'(32'hABCD);
        c_s_axis_tkeep  = '1;
        c_s_axis_tvalid = 1'b1;
        c_s_axis_tlast  = 1'b1;
        n_tests++; if (c_m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL ctrl_pre: got tvalid=%0b expected 0", c_m_axis_tvalid); end
        step();
        n_tests++; if (c_m_axis_tvalid !== 1'b1 || c_m_axis_tlast !== 1'b1 || c_m_axis_tdata !== DW'(32'h1234)
                       || c_m_axis_tuser !== UW'(32'hABCD) || c_m_axis_tkeep !== {KW{1'b1}}) begin
            n_fail++; $display("FAIL ctrl_beat: got tvalid=%0b tlast=%0b tdata=%0h tuser=%0h expected 1/1/1234/abcd",
                               c_m_axis_tvalid, c_m_axis_tlast, c_m_axis_tdata, c_m_axis_tuser);
        end
        c_s_axis_tdata  = DW'(32'h5678);
        c_s_axis_tvalid = 1'b0;
        c_s_axis_tlast  = 1'b0;
        step();
        n_tests++; if (c_m_axis_tvalid !== 1'b0 || c_m_axis_tlast !== 1'b0 || c_m_axis_tdata !== DW'(32'h5678)) begin
            n_fail++; $display("FAIL ctrl_idle: got tvalid=%0b tlast=%0b tdata=%0h expected 0/0/5678",
                               c_m_axis_tvalid, c_m_axis_tlast, c_m_axis_tdata);
        end
    endtask

    initial begin
        aresetn         = 1'b0;
        phv_in          = '0;
        phv_in_valid    = 1'b0;
        stg_ready_in    = 1'b0;
        c_s_axis_tdata  = '0;
        c_s_axis_tuser  = '0;
        c_s_axis_tkeep  = '0;
        c_s_axis_tvalid = 1'b0;
        c_s_axis_tlast  = 1'b0;
        repeat (3) step();
        test_reset();
        test_single();
        test_fill();
        test_full_rw();
        test_wrap();
        test_mid_reset();
        test_ctrl();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
